// File: rtl/rs_station_pkg.sv
// Shared defaults and constants for the reservation station slice.
// Tag value 0 marks an operand whose value is already present.
package rs_station_pkg;

  localparam int ROB_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int OP_W_DEF   = 6;
  localparam int N_CDB_DEF  = 2;

  localparam int TAG_READY = 0;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 6'd1;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 6'd2;
  localparam logic [OP_W_DEF-1:0] OP_AND = 6'd3;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 6'd4;
  localparam logic [OP_W_DEF-1:0] OP_BEQ = 6'd5;
  localparam logic [OP_W_DEF-1:0] OP_BNE = 6'd6;

endpackage

// File: rtl/rs_station_if.sv
// Dispatch, CDB and issue bundle of the reservation station.
// The station takes the slave side; dispatcher/CDB/execution unit the master side.
interface rs_station_if #(
  parameter int ROB_W  = rs_station_pkg::ROB_W_DEF,
  parameter int DATA_W = rs_station_pkg::DATA_W_DEF,
  parameter int PC_W   = rs_station_pkg::PC_W_DEF,
  parameter int OP_W   = rs_station_pkg::OP_W_DEF,
  parameter int N_CDB  = rs_station_pkg::N_CDB_DEF
) ();

  logic                    disp_valid_in;
  logic                    disp_ready_out;
  logic [OP_W-1:0]         disp_op_in;
  logic [ROB_W-1:0]        disp_qj_in;
  logic [ROB_W-1:0]        disp_qk_in;
  logic [DATA_W-1:0]       disp_vj_in;
  logic [DATA_W-1:0]       disp_vk_in;
  logic [DATA_W-1:0]       disp_imm_in;
  logic [ROB_W-1:0]        disp_dest_in;
  logic [PC_W-1:0]         disp_pc_in;

  logic [N_CDB-1:0]        cdb_valid_in;
  logic [N_CDB*ROB_W-1:0]  cdb_tag_in;
  logic [N_CDB*DATA_W-1:0] cdb_data_in;

  logic                    iss_valid_out;
  logic                    iss_ready_in;
  logic [OP_W-1:0]         iss_op_out;
  logic [DATA_W-1:0]       iss_vj_out;
  logic [DATA_W-1:0]       iss_vk_out;
  logic [DATA_W-1:0]       iss_imm_out;
  logic [ROB_W-1:0]        iss_dest_out;
  logic [PC_W-1:0]         iss_pc_out;

  modport slave (
    input  disp_valid_in, disp_op_in, disp_qj_in, disp_qk_in, disp_vj_in,
           disp_vk_in, disp_imm_in, disp_dest_in, disp_pc_in,
    output disp_ready_out,
    input  cdb_valid_in, cdb_tag_in, cdb_data_in,
    output iss_valid_out, iss_op_out, iss_vj_out, iss_vk_out, iss_imm_out,
           iss_dest_out, iss_pc_out,
    input  iss_ready_in
  );

  modport master (
    output disp_valid_in, disp_op_in, disp_qj_in, disp_qk_in, disp_vj_in,
           disp_vk_in, disp_imm_in, disp_dest_in, disp_pc_in,
    input  disp_ready_out,
    output cdb_valid_in, cdb_tag_in, cdb_data_in,
    input  iss_valid_out, iss_op_out, iss_vj_out, iss_vk_out, iss_imm_out,
           iss_dest_out, iss_pc_out,
    output iss_ready_in
  );

endinterface

// File: rtl/rs_age_select.sv
// Oldest-ready selection: an entry wins when no other ready entry is older.
// age[j][i] set means entry j is older than entry i.
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  input  logic [DEPTH-1:0]            ready,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
    logic [DEPTH-1:0] older;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_row
      assign older[gj] = age[gj][gi];
    end
    assign grant[gi] = ready[gi] && !(|(older & ready));
  end

  assign valid = |ready;

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds renamed instructions, wakes operands from the CDBs
// and issues the oldest ready entry; a flush empties it in one cycle.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int N_CDB  = N_CDB_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  rs_station_if.slave            bus,
  output logic [$clog2(DEPTH):0] occupancy_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ROB_W-1:0] TAG0 = ROB_W'(TAG_READY);

  logic [DEPTH-1:0]            busy_reg;
  logic [OP_W-1:0]             op_reg   [DEPTH];
  logic [ROB_W-1:0]            qj_reg   [DEPTH];
  logic [ROB_W-1:0]            qk_reg   [DEPTH];
  logic [DATA_W-1:0]           vj_reg   [DEPTH];
  logic [DATA_W-1:0]           vk_reg   [DEPTH];
  logic [DATA_W-1:0]           imm_reg  [DEPTH];
  logic [ROB_W-1:0]            dest_reg [DEPTH];
  logic [PC_W-1:0]             pc_reg   [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_reg;
  logic [CNT_W-1:0]            occ_reg;

  logic [ROB_W-1:0]  cdb_tag  [N_CDB];
  logic [DATA_W-1:0] cdb_data [N_CDB];
  logic [ROB_W-1:0]  qj_next  [DEPTH];
  logic [ROB_W-1:0]  qk_next  [DEPTH];
  logic [DATA_W-1:0] vj_next  [DEPTH];
  logic [DATA_W-1:0] vk_next  [DEPTH];
  logic [ROB_W-1:0]  disp_qj_next, disp_qk_next;
  logic [DATA_W-1:0] disp_vj_next, disp_vk_next;

  logic [DEPTH-1:0] ready, grant;
  logic             grant_valid, iss_valid, disp_ready, alloc, fire;
  logic [IDX_W-1:0] sel_idx, free_idx;

  for (genvar gi = 0; gi < N_CDB; gi++) begin : g_cdb
    assign cdb_tag[gi]  = bus.cdb_tag_in[gi*ROB_W +: ROB_W];
    assign cdb_data[gi] = bus.cdb_data_in[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
    assign ready[gi] = busy_reg[gi] && (qj_reg[gi] == TAG0) && (qk_reg[gi] == TAG0);
  end

  // Ports are scanned high to low so the lowest matching port has the last word.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      qj_next[i] = qj_reg[i];
      vj_next[i] = vj_reg[i];
      qk_next[i] = qk_reg[i];
      vk_next[i] = vk_reg[i];
      for (int p = N_CDB - 1; p >= 0; p--) begin
        if (bus.cdb_valid_in[p] && qj_reg[i] != TAG0 && qj_reg[i] == cdb_tag[p]) begin
          qj_next[i] = TAG0;
          vj_next[i] = cdb_data[p];
        end
        if (bus.cdb_valid_in[p] && qk_reg[i] != TAG0 && qk_reg[i] == cdb_tag[p]) begin
          qk_next[i] = TAG0;
          vk_next[i] = cdb_data[p];
        end
      end
    end
    disp_qj_next = bus.disp_qj_in;
    disp_vj_next = bus.disp_vj_in;
    disp_qk_next = bus.disp_qk_in;
    disp_vk_next = bus.disp_vk_in;
    for (int p = N_CDB - 1; p >= 0; p--) begin
      if (bus.cdb_valid_in[p] && bus.disp_qj_in != TAG0 && bus.disp_qj_in == cdb_tag[p]) begin
        disp_qj_next = TAG0;
        disp_vj_next = cdb_data[p];
      end
      if (bus.cdb_valid_in[p] && bus.disp_qk_in != TAG0 && bus.disp_qk_in == cdb_tag[p]) begin
        disp_qk_next = TAG0;
        disp_vk_next = cdb_data[p];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) free_idx = IDX_W'(i);
    end
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .age   (age_reg),
    .ready (ready),
    .grant (grant),
    .valid (grant_valid)
  );

  assign iss_valid  = rdy_in && grant_valid;
  assign disp_ready = rdy_in && !(&busy_reg);
  assign fire       = iss_valid && bus.iss_ready_in;
  assign alloc      = bus.disp_valid_in && disp_ready;

  assign bus.iss_valid_out  = iss_valid;
  assign bus.disp_ready_out = disp_ready;
  assign bus.iss_op_out     = op_reg[sel_idx];
  assign bus.iss_vj_out     = vj_reg[sel_idx];
  assign bus.iss_vk_out     = vk_reg[sel_idx];
  assign bus.iss_imm_out    = imm_reg[sel_idx];
  assign bus.iss_dest_out   = dest_reg[sel_idx];
  assign bus.iss_pc_out     = pc_reg[sel_idx];
  assign occupancy_out      = occ_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      busy_reg <= '0;
      age_reg  <= '0;
      occ_reg  <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        qj_reg[i] <= qj_next[i];
        vj_reg[i] <= vj_next[i];
        qk_reg[i] <= qk_next[i];
        vk_reg[i] <= vk_next[i];
      end
      if (fire) busy_reg[sel_idx] <= 1'b0;
      // New entry becomes the youngest: older than nobody, younger than every busy one.
      if (alloc) begin
        busy_reg[free_idx] <= 1'b1;
        op_reg[free_idx]   <= bus.disp_op_in;
        qj_reg[free_idx]   <= disp_qj_next;
        vj_reg[free_idx]   <= disp_vj_next;
        qk_reg[free_idx]   <= disp_qk_next;
        vk_reg[free_idx]   <= disp_vk_next;
        imm_reg[free_idx]  <= bus.disp_imm_in;
        dest_reg[free_idx] <= bus.disp_dest_in;
        pc_reg[free_idx]   <= bus.disp_pc_in;
        for (int i = 0; i < DEPTH; i++) begin
          age_reg[i][free_idx] <= busy_reg[i];
        end
        age_reg[free_idx] <= '0;
      end
      occ_reg <= occ_reg + CNT_W'(alloc) - CNT_W'(fire);
    end
  end

endmodule
